// File: rtl/segment_decode_mon.sv
// segment_decode_mon
//   Watches a 7-segment display drive bus, waits for a pattern to hold
//   steady for STABLE_CYCLES samples, decodes it to a hex digit (or blank /
//   error), and presents the result on a valid/ready output with overrun
//   tracking.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   seg_in[8:0]  : [6:0] segments a..g, [7] decimal point, [8] unused
//   out_valid    : a decoded result is held for the consumer
//   out_ready    : consumer takes the result this cycle
//   out_digit    : decoded hex value (0 for blank / error)
//   out_dp       : decimal point of the result
//   out_blank    : result is an all-off display
//   out_error    : result is not a recognised digit pattern
//   change_count : accepted pattern changes since reset (wraps)
//   overrun      : sticky, a result was replaced before it was consumed
module segment_decode_mon #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic             out_dp,
    output logic             out_blank,
    output logic             out_error,
    output logic [CNT_W-1:0] change_count,
    output logic             overrun
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

    typedef enum logic { TRACK  = 1'b0, LOCKED = 1'b1 } stab_st_e;
    typedef enum logic { EMPTY  = 1'b0, FULL   = 1'b1 } out_st_e;

    stab_st_e         stab_st_q;
    out_st_e          out_st_q;
    logic [7:0]       sample_q;
    logic [SW-1:0]    stab_cnt_q;
    logic [7:0]       last_q;
    logic             last_vld_q;
    logic [3:0]       digit_q;
    logic             dp_q;
    logic             blank_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q;

    logic             same;
    logic             lock_entry;
    logic             accept;
    logic             hit;
    logic [3:0]       dec_digit;
    logic [3:0]       digit_d;
    logic             dp_d;
    logic             blank_d;
    logic             error_d;

    always_comb begin
        // The incoming pin value is compared with the registered sample, so
        // stab_cnt_q counts how many consecutive edges captured the same value.
        same       = (seg_in[7:0] == sample_q);
        lock_entry = (stab_st_q == TRACK) && (stab_cnt_q == STAB_MAX);
        accept     = lock_entry && (!last_vld_q || (sample_q != last_q));

        hit       = 1'b1;
        dec_digit = 4'h0;
        case (sample_q[6:0])
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: hit = 1'b0;
        endcase

        digit_d = 4'h0;
        dp_d    = 1'b0;
        blank_d = 1'b0;
        error_d = 1'b0;
        if (hit) begin
            digit_d = dec_digit;
            dp_d    = sample_q[7];
        end else if (sample_q == 8'h00) begin
            blank_d = 1'b1;
        end else begin
            // Includes a lone decimal point (0x80).
            error_d = 1'b1;
            dp_d    = sample_q[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stab_st_q  <= TRACK;
            out_st_q   <= EMPTY;
            sample_q   <= 8'h00;
            stab_cnt_q <= '0;
            last_q     <= 8'h00;
            last_vld_q <= 1'b0;
            digit_q    <= 4'h0;
            dp_q       <= 1'b0;
            blank_q    <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sample_q <= seg_in[7:0];

            // Stability tracker. On the lock edge the sample may already be
            // moving on; in that case restart tracking straight away so the
            // new value's first edge is not lost.
            case (stab_st_q)
                TRACK: begin
                    if (lock_entry) begin
                        stab_st_q  <= same ? LOCKED : TRACK;
                        stab_cnt_q <= same ? stab_cnt_q : SW'(1);
                    end else begin
                        stab_cnt_q <= same ? stab_cnt_q + SW'(1) : SW'(1);
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        stab_st_q  <= TRACK;
                        stab_cnt_q <= SW'(1);
                    end
                end
                default: stab_st_q <= TRACK;
            endcase

            // Output slot.
            if (accept) begin
                last_q     <= sample_q;
                last_vld_q <= 1'b1;
                digit_q    <= digit_d;
                dp_q       <= dp_d;
                blank_q    <= blank_d;
                error_q    <= error_d;
                count_q    <= count_q + CNT_W'(1);
                if ((out_st_q == FULL) && !out_ready)
                    overrun_q <= 1'b1;
                out_st_q   <= FULL;
            end else if ((out_st_q == FULL) && out_ready) begin
                out_st_q <= EMPTY;
            end
        end
    end

    assign out_valid    = (out_st_q == FULL);
    assign out_digit    = digit_q;
    assign out_dp       = dp_q;
    assign out_blank    = blank_q;
    assign out_error    = error_q;
    assign change_count = count_q;
    assign overrun      = overrun_q;

endmodule
